fft_frame_feeder: RTL

Synthesisable front end for the FFTcore streaming input. It takes one real audio sample per strobe from the ADC/codec path and buffers the samples in a small FIFO. It frames them into FRAME_LEN-beat Avalon-ST packets with sop/eop, backpressure and optional pacing. Overflows are handled by zero-padding the frame in flight so the FFT never sees a malformed frame. It replaces hand-generated sink_valid/sop/eop stimulus with a parametrised block that sits between the audio receiver and FFTcore.

---
 rtl/fft_feed_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 61 ++++++
 rtl/fft_frame_feeder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fft_feed_pkg.sv
// Shared types for the FFT frame feeder.
// State encoding, error codes and index-width helper.
package fft_feed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2
  } feed_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PADDED = 2'b01;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with flush.
// Show-ahead read port; flush wins over push and pop.
module sample_fifo
  import fft_feed_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [idx_w(DEPTH):0]    count
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Frames buffered audio samples into Avalon-ST packets for FFTcore.
// Overflow zero-pads the frame in flight so every frame is well formed.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int PACE       = 1
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_error,
  output logic              overflow,
  input  logic              ovf_clear,
  output logic [15:0]       frame_count
);

  localparam int IW = idx_w(FRAME_LEN);
  localparam int CW = idx_w(FIFO_DEPTH) + 1;
  localparam int PW = idx_w(PACE);

  localparam logic [IW-1:0] LAST     = IW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PACE_MAX = PW'(PACE - 1);
  localparam logic [CW-1:0] CAP      = CW'(FIFO_DEPTH);

  feed_state_e       state_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [PW-1:0]     pace_q;
  logic              pad_req_q;
  logic              flush_q;
  logic              overflow_q;
  logic [15:0]       frame_cnt_q;

  logic              out_valid_q;
  logic              out_sop_q;
  logic              out_eop_q;
  logic [1:0]        out_err_q;
  logic [DATA_W-1:0] out_real_q;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  logic              xfer;
  logic              slot_free;
  logic              pace_ok;
  logic              gate_ok;
  logic              push;
  logic              pop;
  logic              ovf_evt;

  assign xfer      = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || xfer;
  assign idx_d     = xfer ? idx_q + 1'b1 : idx_q;
  assign gate_ok   = (state_q != IDLE) || enable;

  // A load now shows the beat next cycle, so look one cycle ahead.
  assign pace_ok = xfer ? (PACE == 1)
                        : (int'(pace_q) + 2 >= PACE);

  assign pop = !pad_req_q && !fifo_empty && pace_ok &&
               ((state_q == IDLE && enable) ||
                (state_q == RUN && slot_free &&
                 !(xfer && out_eop_q)));

  assign ovf_evt = in_valid && gate_ok && !flush_q &&
                   (fifo_cnt == CAP) && !pop;

  assign push = in_valid && gate_ok && !flush_q &&
                (!fifo_full || pop);

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MCLK),
    .rst_n (reset),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .flush (flush_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pace_q      <= PACE_MAX;
      pad_req_q   <= 1'b0;
      flush_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= ERR_NONE;
    end else begin
      flush_q <= ovf_evt;
      if (ovf_evt)
        overflow_q <= 1'b1;
      else if (ovf_clear)
        overflow_q <= 1'b0;
      if (xfer)
        pace_q <= '0;
      else if (pace_q != PACE_MAX)
        pace_q <= pace_q + 1'b1;
      if (xfer) begin
        out_valid_q <= 1'b0;
        out_sop_q   <= 1'b0;
        out_eop_q   <= 1'b0;
        out_err_q   <= ERR_NONE;
      end
      unique case (state_q)
        IDLE: begin
          if (pad_req_q) begin
            pad_req_q <= 1'b0;
          end else if (pop) begin
            state_q     <= RUN;
            out_valid_q <= 1'b1;
            out_real_q  <= fifo_rdata;
            out_sop_q   <= 1'b1;
            out_eop_q   <= 1'b0;
            out_err_q   <= ERR_NONE;
          end
        end
        RUN: begin
          if (xfer && out_eop_q) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end else begin
            idx_q <= idx_d;
            if (pad_req_q && slot_free) begin
              state_q <= PAD;
            end else if (pop) begin
              out_valid_q <= 1'b1;
              out_real_q  <= fifo_rdata;
              out_sop_q   <= (idx_d == '0);
              out_eop_q   <= (idx_d == LAST);
              out_err_q   <= ERR_NONE;
            end
          end
        end
        PAD: begin
          if (xfer && out_eop_q) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            pad_req_q   <= 1'b0;
          end else begin
            idx_q <= idx_d;
            if (slot_free && pace_ok) begin
              out_valid_q <= 1'b1;
              out_real_q  <= '0;
              out_sop_q   <= (idx_d == '0);
              out_eop_q   <= (idx_d == LAST);
              out_err_q   <= (idx_d == LAST) ? ERR_PADDED
                                             : ERR_NONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A fresh overflow outranks any clear above.
      if (ovf_evt) pad_req_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_real    = out_real_q;
  assign out_imag    = '0;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_error   = out_err_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_cnt_q;

endmodule
